// File: rtl/window_streamer.sv
// window_streamer: sliding-window generator with line buffers, stride and border padding (define WINDOW_STREAMER_REPLICATE_PAD_EN for edge replication instead of zero padding)
module window_streamer #(
  parameter int WINDOW_SIZE = 3,
  parameter int STRIDE = 1,
  parameter int DWIDTH = 8,
  parameter int IMG_WIDTH = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                                        clock,
  input  logic                                        reset,
  output logic                                        fifo_in_rd_en,
  input  logic [DWIDTH-1:0]                           fifo_in_dout,
  input  logic                                        fifo_in_empty,
  output logic                                        win_valid,
  input  logic                                        win_ready,
  output logic [DWIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0]   win_data,
  output logic [$clog2(IMG_WIDTH)-1:0]                win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]               win_y,
  output logic                                        win_eof
);
  localparam int K = WINDOW_SIZE;
  localparam int P = K / 2;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] XP = XW'(P);
  localparam logic [YW-1:0] YP = YW'(P);
  localparam logic [XW-1:0] LX = XW'(((IMG_WIDTH - 1) / STRIDE) * STRIDE);
  localparam logic [YW-1:0] LY = YW'(((IMG_HEIGHT - 1) / STRIDE) * STRIDE);
`ifdef WINDOW_STREAMER_REPLICATE_PAD_EN
  localparam int IW = $clog2(K);
`endif
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
  state_t state, state_nx;
  logic [XW-1:0] rx, px;
  logic [YW-1:0] ry, py;
  logic walked, live, want, occupied, step, load, restart;
  logic [DWIDTH-1:0] pix;
  logic [DWIDTH-1:0] lb [K-1][IMG_WIDTH];
  logic [DWIDTH-1:0] win [K][K];
  logic [DWIDTH-1:0] nwin [K][K];
  logic [DWIDTH-1:0] col [K];
  logic [DWIDTH*K*K-1:0] padded;
  int iy, ix;
  // Each advance pushes one column and walks one center position, lagging the read position by P rows and P columns; flush steps push dummy columns.
  always_comb begin
    occupied = win_valid && !win_ready;
    live = state != FILL || (ry == YP && rx == XP);
    want = live && !walked && int'(px) % STRIDE == 0 && int'(py) % STRIDE == 0;
    step = !reset && (state == FLUSH ? !walked : !fifo_in_empty) && !(want && occupied);
    load = step && want;
    fifo_in_rd_en = state != FLUSH && step;
    restart = state == FLUSH && walked && !occupied;
    pix = state == FLUSH ? '0 : fifo_in_dout;
    state_nx = state;
    if (state == FILL && step && live) state_nx = STREAM;
    else if (state == STREAM && step && ry == YMAX && rx == XMAX) state_nx = FLUSH;
    else if (restart) state_nx = FILL;
  end
  // Next window: shift left by one column and append the column formed by the line buffers and the new pixel, then pad out-of-image taps.
  always_comb begin
    padded = '0;
    iy = 0;
    ix = 0;
    col[K-1] = pix;
    for (int r = 0; r < K - 1; r++) col[r] = lb[K-2-r][rx];
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) nwin[r][c] = win[r][c+1];
      nwin[r][K-1] = col[r];
    end
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        iy = int'(py) - P + r;
        ix = int'(px) - P + c;
`ifdef WINDOW_STREAMER_REPLICATE_PAD_EN
        iy = iy < 0 ? 0 : (iy > IMG_HEIGHT - 1 ? IMG_HEIGHT - 1 : iy);
        ix = ix < 0 ? 0 : (ix > IMG_WIDTH - 1 ? IMG_WIDTH - 1 : ix);
        padded[(r*K+c)*DWIDTH +: DWIDTH] = nwin[IW'(iy - int'(py) + P)][IW'(ix - int'(px) + P)];
`else
        padded[(r*K+c)*DWIDTH +: DWIDTH] = (iy < 0 || iy >= IMG_HEIGHT || ix < 0 || ix >= IMG_WIDTH) ? '0 : nwin[r][c];
`endif
      end
  end
  // Line buffers and window register; stale contents from a previous frame or reset are always masked by padding.
  always_ff @(posedge clock) begin
    if (step) begin
      lb[0][rx] <= pix;
      for (int i = 1; i < K - 1; i++) lb[i][rx] <= lb[i-1][rx];
      win <= nwin;
    end
  end
  // State register.
  always_ff @(posedge clock) begin
    state <= reset ? FILL : state_nx;
  end
  // Read column/row counters and center-position walk.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      rx <= '0;
      ry <= '0;
      px <= '0;
      py <= '0;
      walked <= 1'b0;
    end else if (step) begin
      rx <= rx == XMAX ? '0 : rx + 1'b1;
      ry <= state != FLUSH && rx == XMAX ? ry + 1'b1 : ry;
      if (live) begin
        px <= px == XMAX ? '0 : px + 1'b1;
        py <= px == XMAX ? py + 1'b1 : py;
        walked <= px == XMAX && py == YMAX;
      end
    end
  end
  // Output register: reloads on a new window, otherwise drops valid once accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_data <= '0;
      win_x <= '0;
      win_y <= '0;
      win_eof <= 1'b0;
    end else if (load) begin
      win_valid <= 1'b1;
      win_data <= padded;
      win_x <= px;
      win_y <= py;
      win_eof <= px == LX && py == LY;
    end else if (win_ready) win_valid <= 1'b0;
  end
endmodule
